mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch unit (IF) and the load/store unit (LS) of the RV32 core.
- Runs a 3-state sequencer and allows at most one outstanding memory transaction.
- Handles the request/grant handshake toward memory and routes each response back to the requester that owns it.
- Sits between the fetch/LSU logic and the single-ported memory wrapper.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RSP} arb_state_t;

    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    // Wide enough for any DW up to 512; users slice the low DW/8 bits.
    localparam logic [63:0] BE_FULL = '1;

endpackage

// File: rtl/arb_pick.sv
// Combinational requester picker. Fixed LS priority by default; round-robin on
// last_owner when ARB_RR_EN is defined.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last_owner,
    output logic sel_valid,
    output logic sel_owner
);

`ifndef ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        sel_valid = if_req | ls_req;
        sel_owner = ls_req ? OWN_LS : OWN_IF;
        if (if_req && ls_req) begin
`ifdef ARB_RR_EN
            sel_owner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
`else
            sel_owner = OWN_LS;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with at most
// one outstanding transaction. Define ARB_RR_EN for round-robin picking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned BW = DW / 8;

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_owner_q, last_owner_d;
    logic            we_q, we_d;
    logic [BW-1:0]   be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            sel_valid, sel_owner, load;

    arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_owner (last_owner_q),
        .sel_valid  (sel_valid),
        .sel_owner  (sel_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load         = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        ls_rvalid    = 1'b0;
        rdata        = '0;

        unique case (state_q)
            S_IDLE: load = sel_valid;
            S_WAIT_GNT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if_gnt    = mem_gnt && (owner_q == OWN_IF);
                ls_gnt    = mem_gnt && (owner_q == OWN_LS);
                if (mem_gnt) begin
                    state_d      = S_WAIT_RSP;
                    last_owner_d = owner_q;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rvalid) begin
                    if_rvalid = (owner_q == OWN_IF);
                    ls_rvalid = (owner_q == OWN_LS);
                    rdata     = mem_rdata;
                    // Back-to-back issue: the next pick happens on the response edge.
                    load      = sel_valid;
                    if (!sel_valid) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_WAIT_GNT;
            owner_d = owner_t'(sel_owner);
            if (sel_owner == OWN_LS) begin
                we_d    = ls_we;
                be_d    = ls_be;
                addr_d  = ls_addr;
                wdata_d = ls_wdata;
            end else begin
                we_d    = 1'b0;
                be_d    = BE_FULL[BW-1:0];
                addr_d  = if_addr;
                wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Requesters must hold req and its fields stable until granted.
    if_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (if_req && !if_gnt) |=> (if_req && $stable(if_addr)));

    ls_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ls_req && !ls_gnt) |=> (ls_req && $stable({ls_we, ls_be, ls_addr, ls_wdata})));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_be      (ls_be),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] any;
        any = {22'd0, mem_req, mem_we, mem_be, if_gnt, ls_gnt, if_rvalid, ls_rvalid}
              | mem_addr | mem_wdata | rdata;
        check(tag, any, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serves the transaction that is expected to be presented on the memory port now.
    task automatic do_txn(input bit is_ls, input logic [31:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] data);
        mem_gnt = 1'b1;
        @(negedge clk);
        check("txn_mem_req", mem_req, 1);
        check("txn_addr", mem_addr, addr);
        check("txn_we", mem_we, we);
        check("txn_be", mem_be, be);
        if (is_ls) check("txn_wdata", mem_wdata, wdata);
        check("txn_if_gnt", if_gnt, !is_ls);
        check("txn_ls_gnt", ls_gnt, is_ls);
        tick();
        if (is_ls) ls_req = 1'b0;
        else if_req = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        check("rsp_mem_req", mem_req, 0);
        check("rsp_if_rvalid", if_rvalid, !is_ls);
        check("rsp_ls_rvalid", ls_rvalid, is_ls);
        check("rsp_rdata", rdata, data);
        tick();
        mem_rvalid = 1'b0;
    endtask

    function automatic bit pick_ls(input bit i, input bit l, input bit last_ls);
        if (i && l) begin
`ifdef ARB_RR_EN
            return !last_ls;
`else
            return 1'b1;
`endif
        end
        return l;
    endfunction

    // Reference model: one in-flight transaction, described by its request and phase.
    bit          m_active, m_granted, m_ls, m_last_ls;
    bit          m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    bit          exp_req, rsp, gnt_if, gnt_ls;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_zero("idle_quiet");
        end
        tick();

        // IF read, one cycle of gnt latency.
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        check("if_latency_mem_req", mem_req, 0);
        tick();
        @(negedge clk);
        check("if_wait_mem_req", mem_req, 1);
        check("if_wait_if_gnt", if_gnt, 0);
        tick();
        do_txn(0, 32'h100, 0, 4'hF, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        check("if_done_rvalid", if_rvalid, 0);
        check("if_done_rdata", rdata, 0);
        tick();

        // Simultaneous requests with last owner IF: LS first, then IF with no bubble.
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_addr = 32'h200; ls_wdata = 32'h1234;
        tick();
        do_txn(1, 32'h200, 1, 4'h3, 32'h1234, 32'h55);
        do_txn(0, 32'h300, 0, 4'hF, 32'h0, 32'h66);

        // Memory stall of five cycles while IF also waits.
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hC; ls_addr = 32'h400; ls_wdata = 32'h0;
        tick();
        if_req = 1'b1; if_addr = 32'h500;
        repeat (5) begin
            @(negedge clk);
            check("stall_mem_req", mem_req, 1);
            check("stall_addr", mem_addr, 32'h400);
            check("stall_be", mem_be, 4'hC);
            check("stall_ls_gnt", ls_gnt, 0);
            check("stall_if_gnt", if_gnt, 0);
            tick();
        end
        do_txn(1, 32'h400, 0, 4'hC, 32'h0, 32'h77);
        do_txn(0, 32'h500, 0, 4'hF, 32'h0, 32'h88);

        // LS alone, then both with last owner LS.
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h600; ls_wdata = 32'hA5;
        tick();
        do_txn(1, 32'h600, 1, 4'hF, 32'hA5, 32'h99);
        if_req = 1'b1; if_addr = 32'h700;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h1; ls_addr = 32'h800; ls_wdata = 32'h5A;
        tick();
`ifdef ARB_RR_EN
        do_txn(0, 32'h700, 0, 4'hF, 32'h0, 32'h11);
        do_txn(1, 32'h800, 1, 4'h1, 32'h5A, 32'h22);
`else
        do_txn(1, 32'h800, 1, 4'h1, 32'h5A, 32'h22);
        do_txn(0, 32'h700, 0, 4'hF, 32'h0, 32'h11);
`endif

        // Spurious response and grant while idle.
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF0000;
        repeat (2) begin
            @(negedge clk);
            check("spur_if_rvalid", if_rvalid, 0);
            check("spur_ls_rvalid", ls_rvalid, 0);
            check("spur_rdata", rdata, 0);
            check("spur_mem_req", mem_req, 0);
            tick();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;

        // Reset while waiting for a response.
        if_req = 1'b1; if_addr = 32'h900;
        tick();
        mem_gnt = 1'b1;
        @(negedge clk);
        check("rst_pre_if_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hABCD;
        #1;
        check("rst_pre_if_rvalid", if_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async_zero");
        mem_rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("late_if_rvalid", if_rvalid, 0);
        check("late_ls_rvalid", ls_rvalid, 0);
        check("late_rdata", rdata, 0);
        tick();
        mem_rvalid = 1'b0;

        // Randomized traffic against the transaction model; arbiter is idle, last owner IF.
        m_active = 0; m_granted = 0; m_ls = 0; m_last_ls = 0;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        repeat (3000) begin
            @(negedge clk);
            exp_req = m_active && !m_granted;
            rsp     = m_active && m_granted && mem_rvalid;
            gnt_if  = exp_req && !m_ls && mem_gnt;
            gnt_ls  = exp_req && m_ls && mem_gnt;
            check("rnd_mem_req", mem_req, exp_req);
            if (exp_req) begin
                check("rnd_mem_addr", mem_addr, m_addr);
                check("rnd_mem_we", mem_we, m_we);
                check("rnd_mem_be", mem_be, m_be);
                if (m_ls) check("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            check("rnd_if_gnt", if_gnt, gnt_if);
            check("rnd_ls_gnt", ls_gnt, gnt_ls);
            check("rnd_if_rvalid", if_rvalid, rsp && !m_ls);
            check("rnd_ls_rvalid", ls_rvalid, rsp && m_ls);
            check("rnd_rdata", rdata, rsp ? mem_rdata : 32'h0);

            if (exp_req && mem_gnt) begin
                m_granted = 1;
                m_last_ls = m_ls;
            end else if (!m_active || rsp) begin
                m_active = if_req || ls_req;
                if (m_active) begin
                    m_granted = 0;
                    m_ls = pick_ls(if_req, ls_req, m_last_ls);
                    m_we    = m_ls ? ls_we : 1'b0;
                    m_be    = m_ls ? ls_be : 4'hF;
                    m_addr  = m_ls ? ls_addr : if_addr;
                    m_wdata = ls_wdata;
                end
            end

            tick();
            if (gnt_if) if_req = 1'b0;
            if (gnt_ls) ls_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req   = 1'b1;
                ls_we    = 1'($urandom);
                ls_be    = 4'($urandom);
                ls_addr  = $urandom;
                ls_wdata = $urandom;
            end
            mem_gnt    = 1'($urandom);
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
